// File: rtl/arb_pkg.sv
// Shared types and helpers for the 16-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // 16-to-4 one-hot encode as an OR tree: index bit b is the OR of every
    // input line whose position has bit b set (same mapping as the 16x4 encoder).
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int b = 0; b < IDX_W; b++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i[b]) idx[b] = idx[b] | oh[i];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr (circularly) wins. Rotate so ptr lands on bit 0, isolate the lowest set
// bit, rotate back and encode.
module rr_pick16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] rot_oh;
    logic [N_REQ-1:0] win_oh;

    // Rotate, fixed-priority scan, un-rotate; the 4-bit index sum wraps mod 16.
    always_comb begin
        rot    = '0;
        win_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[IDX_W'(i) + ptr];
        end
        rot_oh = rot & (~rot + N_REQ'(1));
        for (int i = 0; i < N_REQ; i++) begin
            win_oh[IDX_W'(i) + ptr] = rot_oh[i];
        end
        any     = |req;
        win_idx = onehot2idx(win_oh);
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters sharing one resource. Registered
// one-hot grant plus index, with a bounded hold time under contention and a
// mandatory idle cycle between any two grants.
module rr_arbiter16 #(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 8   // 0 = unlimited; must fit in 4 bits
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    import arb_pkg::*;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);
    // Counter saturation point; with no limit it just parks at all-ones.
    localparam logic [3:0] HOLD_CAP = (MAX_HOLD == 0) ? 4'd15 : 4'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [3:0]       hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic             others;
    logic             limit_hit;

    rr_pick16 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .any     (pick_any),
        .win_idx (pick_idx)
    );

    // Next-state, pointer, hold counter and output register values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        others    = |(req & ~gnt_q);
        limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && others;
        unique case (state_q)
            IDLE: begin
                if (en && pick_any) begin
                    state_d         = GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    idx_d           = pick_idx;
                    hold_d          = 4'd1;
                    vld_d           = 1'b1;
                end
            end
            GRANT: begin
                if (!en) begin
                    // Enable drop wins over a simultaneous request drop: ptr stays.
                    state_d = IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    hold_d  = 4'd0;
                end else if (!req[idx_q] || limit_hit) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    hold_d  = 4'd0;
                    ptr_d   = idx_q + IDX_W'(1);
                end else if (hold_q != HOLD_CAP) begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: a table of single-cycle vectors on a MAX_HOLD=8
// instance, then hand sequences for hold limit, lone holder, async reset and
// full rotation on an unlimited-hold instance.
module tb_rr_arbiter16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, en0;
    logic [15:0] req, req0;
    logic [15:0] gnt, gnt0;
    logic [3:0]  gnt_idx, gnt_idx0;
    logic        gnt_valid, gnt_valid0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        en;
        logic [15:0] req;
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        vld;
        string       name;
    } vec_t;

    typedef struct {
        bit          sel;
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        vld;
        string       name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter16 #(.N_REQ(16), .IDX_W(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    rr_arbiter16 #(.N_REQ(16), .IDX_W(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .req(req0),
        .gnt(gnt0), .gnt_idx(gnt_idx0), .gnt_valid(gnt_valid0)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then
    // pop and compare them one time unit after the edge.
    task automatic cyc(input bit sel, input logic e, input logic [15:0] r,
                       input logic [15:0] eg, input logic [3:0] ei, input logic ev,
                       input string nm);
        exp_t x;
        if (sel) begin en0 = e; req0 = r; end
        else begin en = e; req = r; end
        x = '{sel, eg, ei, ev, nm};
        sb.push_back(x);
        @(posedge clk); #1;
        x = sb.pop_front();
        if (x.sel) begin
            check({x.name, ".gnt"}, gnt0, x.gnt);
            check({x.name, ".idx"}, {12'd0, gnt_idx0}, {12'd0, x.idx});
            check({x.name, ".vld"}, {15'd0, gnt_valid0}, {15'd0, x.vld});
        end else begin
            check({x.name, ".gnt"}, gnt, x.gnt);
            check({x.name, ".idx"}, {12'd0, gnt_idx}, {12'd0, x.idx});
            check({x.name, ".vld"}, {15'd0, gnt_valid}, {15'd0, x.vld});
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req = '0; en0 = 1'b0; req0 = '0;

        //           en    req       gnt       idx    vld
        tbl.push_back('{1'b1, 16'h0001, 16'h0001, 4'd0,  1'b1, "first_grant"});
        tbl.push_back('{1'b1, 16'h0001, 16'h0001, 4'd0,  1'b1, "hold0"});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b0, "rel0_ptr1"});
        tbl.push_back('{1'b1, 16'h0003, 16'h0002, 4'd1,  1'b1, "ptr1_pick1"});
        tbl.push_back('{1'b1, 16'h0001, 16'h0000, 4'd1,  1'b0, "rel1_ptr2"});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 4'd1,  1'b0, "idle_keep_idx"});
        tbl.push_back('{1'b0, 16'h0008, 16'h0000, 4'd1,  1'b0, "en_low_blocks"});
        tbl.push_back('{1'b1, 16'h0008, 16'h0008, 4'd3,  1'b1, "grant3"});
        tbl.push_back('{1'b0, 16'h0008, 16'h0000, 4'd3,  1'b0, "en_drop_rel"});
        tbl.push_back('{1'b0, 16'h0008, 16'h0000, 4'd3,  1'b0, "en_drop_idle"});
        tbl.push_back('{1'b1, 16'h0018, 16'h0008, 4'd3,  1'b1, "en_back_ptr_kept"});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 4'd3,  1'b0, "rel3_ptr4"});
        tbl.push_back('{1'b1, 16'h2000, 16'h2000, 4'd13, 1'b1, "grant13"});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 4'd13, 1'b0, "rel13_ptr14"});
        tbl.push_back('{1'b1, 16'h0003, 16'h0001, 4'd0,  1'b1, "wrap_pick0"});
        tbl.push_back('{1'b1, 16'h0002, 16'h0000, 4'd0,  1'b0, "rel0_ptr1b"});
        tbl.push_back('{1'b1, 16'h0003, 16'h0002, 4'd1,  1'b1, "wrap_pick1"});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 4'd1,  1'b0, "rel1_ptr2b"});
        tbl.push_back('{1'b1, 16'h0020, 16'h0020, 4'd5,  1'b1, "grant5"});
        tbl.push_back('{1'b0, 16'h0000, 16'h0000, 4'd5,  1'b0, "en_and_req_fall"});
        tbl.push_back('{1'b1, 16'h0048, 16'h0008, 4'd3,  1'b1, "ptr2_still"});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 4'd3,  1'b0, "rel3_ptr4b"});

        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt", gnt, 16'h0000);
        check("reset.idx", {12'd0, gnt_idx}, 16'h0000);
        check("reset.vld", {15'd0, gnt_valid}, 16'h0000);
        rst_n = 1'b1;

        foreach (tbl[i])
            cyc(1'b0, tbl[i].en, tbl[i].req, tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].name);

        // Hold limit: ptr=4, req5 granted, req9 joins one cycle later.
        cyc(1'b0, 1'b1, 16'h0020, 16'h0020, 4'd5, 1'b1, "hold_c1");
        for (int k = 2; k <= 8; k++)
            cyc(1'b0, 1'b1, 16'h0220, 16'h0020, 4'd5, 1'b1, $sformatf("hold_c%0d", k));
        cyc(1'b0, 1'b1, 16'h0220, 16'h0000, 4'd5, 1'b0, "hold_gap");
        cyc(1'b0, 1'b1, 16'h0220, 16'h0200, 4'd9, 1'b1, "hold_next9");
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 4'd9, 1'b0, "rel9_ptr10");

        // Lone holder never preempted.
        for (int k = 0; k < 50; k++)
            cyc(1'b0, 1'b1, 16'h0100, 16'h0100, 4'd8, 1'b1, $sformatf("lone_%0d", k));
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 4'd8, 1'b0, "lone_rel");

        // Async reset in the middle of a grant.
        cyc(1'b0, 1'b1, 16'h0002, 16'h0002, 4'd1, 1'b1, "pre_reset_grant");
        #3 rst_n = 1'b0;
        #1;
        check("async_rst.gnt", gnt, 16'h0000);
        check("async_rst.idx", {12'd0, gnt_idx}, 16'h0000);
        check("async_rst.vld", {15'd0, gnt_valid}, 16'h0000);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b1, 16'h0001, 16'h0001, 4'd0, 1'b1, "post_reset_grant");
        cyc(1'b0, 1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, "post_reset_rel");

        // Full rotation on the unlimited-hold instance.
        cyc(1'b1, 1'b1, 16'hFFFF, 16'h0001, 4'd0, 1'b1, "rot_g0");
        for (int i = 0; i < 16; i++) begin
            logic [15:0] drop;
            logic [15:0] nxt;
            drop = 16'hFFFF;
            drop[i] = 1'b0;
            nxt = '0;
            nxt[(i + 1) % 16] = 1'b1;
            cyc(1'b1, 1'b1, drop, 16'h0000, 4'(i), 1'b0, $sformatf("rot_gap%0d", i));
            cyc(1'b1, 1'b1, 16'hFFFF, nxt, 4'((i + 1) % 16), 1'b1,
                $sformatf("rot_g%0d", (i + 1) % 16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter that shares a single 16-input encoder/resource between 16 requesters. It accepts a 16-bit request vector and grants exactly one requester at a time with rotating priority. It drives a one-hot grant and the matching 4-bit index, so downstream logic sees the same `a[3:0]` code a 16×4 encoder would give for that line. It sits between the requester array and the shared datapath and bounds grant hold time under contention.

## Interface
- `N_REQ`, 16: number of requesters. Fixed at 16 in this revision.
- `IDX_W`, 4: grant index width, log2(N_REQ).
- `MAX_HOLD`, 8: maximum cycles a grant is held while another request is pending. 0 = unlimited.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `en`, in, 1: arbiter enable. Low forces release and blocks new grants.
- `req`, in, 16: request vector. Bit i is requester i, level-sensitive.
- `gnt`, out, 16: one-hot grant, registered. All zeros when idle.
- `gnt_idx`, out, 4: binary index of the granted requester, registered. Holds its last value when idle.
- `gnt_valid`, out, 1: high while any grant is active. Equals `|gnt`.

## Operation
- Two states: IDLE and GRANT. Internal registers:
  - `ptr` (4 b): highest-priority index.
  - `hold_cnt` (4 b, saturating at MAX_HOLD).
- **Reset:** state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0. Reset takes effect immediately and asynchronously, including in the middle of a grant.
- **IDLE → GRANT:** when `en`=1 and `|req`=1.
  - Winner = first set bit of `req` scanning circularly ptr, ptr+1, …, 15, 0, …, ptr−1.
  - Load gnt=1<<w, gnt_idx=w, hold_cnt=1.
- **GRANT → IDLE:** on the first of the following conditions:
  - (a) `req[gnt_idx]`=0;
  - (b) `en`=0;
  - (c) MAX_HOLD≠0, hold_cnt==MAX_HOLD, and `req` has any bit other than gnt_idx set.
- On release: gnt=0, gnt_valid=0, gnt_idx unchanged.
  - For (a) and (c): ptr = gnt_idx+1, mod 16 (15 wraps to 0).
  - For (b): ptr unchanged.
- **Staying in GRANT:** hold_cnt increments, saturating at MAX_HOLD. A lone requester with no contender keeps the grant indefinitely.
- Every release passes through IDLE for one cycle, so back-to-back grants are separated by one dead cycle. gnt is never asserted on two lines, and a grant never switches directly from one line to another.
- Requests that rise and fall while another grant is active are not remembered.

## Timing
- Outputs are fully registered. No combinational path from `req` or `en` to any output.
- Grant latency: `req` sampled high at edge t in IDLE gives gnt valid after edge t, i.e. 1 cycle.
- Release latency: `req[gnt_idx]` sampled low at edge t gives gnt=0 after edge t.
- Minimum grant length: 1 cycle. Minimum gap between grants: 1 cycle.
- Contended grant: at most MAX_HOLD cycles with gnt high, then 1 idle cycle, then the next requester in rotation.
- Simultaneous `en` fall and `req` fall: treated as case (b), ptr unchanged.
- Simultaneous case (a) and case (c): ptr advances once.

## Structure
- Shared package `arb_pkg` holds:
  - N_REQ and IDX_W;
  - state enum {IDLE, GRANT};
  - function `onehot2idx` (16→4 encode, same OR-tree mapping as the team's 16×4 encoder).
- Sub-module `rr_pick16`: combinational rotating priority picker.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: any, win_idx[3:0].
  - Implementation: rotate, fixed-priority scan, un-rotate.
- Top level holds the FSM, ptr, hold_cnt and output registers.

## Test plan
- **Reset values:** assert rst_n=0 mid-grant → gnt=0, gnt_idx=0, gnt_valid=0 immediately. After release: req=16'h0001 → gnt=16'h0001, idx=0, one cycle later.
- **Rotation:** req=16'hFFFF held, MAX_HOLD=0, each requester drops req one cycle after its grant → grant order 0,1,2,…,15,0 with one idle cycle between grants.
- **Wrap-around:** ptr=14, req=16'h0003 → grant idx 0, then ptr=1. Next grant with req=16'h0003 → idx 1.
- **Hold limit:** MAX_HOLD=8, req[5] held high, req[9] rises one cycle after the grant → gnt[5] high exactly 8 cycles, 1 idle cycle, then gnt[9], idx=9.
- **Lone holder:** req=16'h0100 held for 50 cycles, MAX_HOLD=8 → gnt=16'h0100 continuous for 50 cycles, with no preemption.
- **Enable drop:** grant to idx 3 with ptr=3, en=0 for 2 cycles → gnt=0 and no new grant. Restore en with req[3] high → idx 3 granted again (ptr unchanged).
